// File: rtl/div_sequencer.sv
//==============================================================================
// Module      : div_sequencer
// Description : Iterative 32-bit signed/unsigned integer divider with its own
//               sequencing FSM. Radix-2 restoring divide, one quotient bit
//               per cycle, followed by sign fixup. Divide-by-zero and the
//               signed overflow case (0x80000000 / -1) finish early.
// Ports       : clk, reset (async, active-high)
//               enable_i    - pipeline advance; low freezes everything but abort
//               abort_i     - flush; returns to IDLE, results untouched
//               start_i     - request, sampled in IDLE with enable_i high
//               is_signed_i - two's complement operands
//               dividend_i, divisor_i - operands, sampled with start_i
//               busy_o, done_o, flags_load_o - decoded from the state register
//               quotient_o, remainder_o      - registered results
//               flag_zero_o, flag_negative_o, flag_div0_o, flag_overflow_o
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        abort_i,
    input  logic        start_i,
    input  logic        is_signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        flags_load_o,
    output logic        flag_zero_o,
    output logic        flag_negative_o,
    output logic        flag_div0_o,
    output logic        flag_overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_ITERATE = 3'd2,
        S_FIXUP   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;

    // Working registers. quo_q starts as |dividend| and is shifted out MSB
    // first while quotient bits shift in at the bottom.
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  count_q, count_d;
    logic        dvd_neg_q, dvd_neg_d;   // only ever set for signed operations
    logic        dvs_neg_q, dvs_neg_d;

    // Architected results
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        zero_q, zero_d;
    logic        neg_q, neg_d;
    logic        div0_q, div0_d;
    logic        ovf_q, ovf_d;

    logic        w_in_dvd_neg;
    logic        w_in_dvs_neg;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_fits;
    logic [31:0] w_dvd_orig;
    logic        w_overflow;
    logic [31:0] w_fix_quo;
    logic [31:0] w_fix_rem;

    assign w_in_dvd_neg = is_signed_i & dividend_i[31];
    assign w_in_dvs_neg = is_signed_i & divisor_i[31];

    assign w_shift = {rem_q, quo_q[31]};
    assign w_trial = w_shift - {1'b0, dvs_q};
    assign w_fits  = ~w_trial[32];

    // Negating |dividend| restores the original operand, including 0x80000000.
    assign w_dvd_orig = dvd_neg_q ? (32'd0 - quo_q) : quo_q;

    // |dividend| == 2^31 with a negative sign is only 0x80000000; |divisor| == 1
    // with a negative sign is only 0xFFFFFFFF.
    assign w_overflow = dvd_neg_q & (quo_q == 32'h8000_0000) &
                        dvs_neg_q & (dvs_q == 32'd1);

    assign w_fix_quo = (dvd_neg_q ^ dvs_neg_q) ? (32'd0 - quo_q) : quo_q;
    assign w_fix_rem = dvd_neg_q ? (32'd0 - rem_q) : rem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvs_q       <= 32'd0;
            count_q     <= 5'd0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            count_q     <= count_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        count_d     = count_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;

        if (abort_i) begin
            // Flush wins over everything, including a same-cycle start.
            state_d = S_IDLE;
        end else if (enable_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        dvd_neg_d = w_in_dvd_neg;
                        dvs_neg_d = w_in_dvs_neg;
                        quo_d     = w_in_dvd_neg ? (32'd0 - dividend_i) : dividend_i;
                        dvs_d     = w_in_dvs_neg ? (32'd0 - divisor_i) : divisor_i;
                        state_d   = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (dvs_q == 32'd0) begin
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = w_dvd_orig;
                        zero_d      = 1'b0;
                        neg_d       = 1'b1;
                        div0_d      = 1'b1;
                        ovf_d       = 1'b0;
                        state_d     = S_DONE;
                    end else if (w_overflow) begin
                        quotient_d  = 32'h8000_0000;
                        remainder_d = 32'd0;
                        zero_d      = 1'b0;
                        neg_d       = 1'b1;
                        div0_d      = 1'b0;
                        ovf_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        rem_d   = 32'd0;
                        count_d = 5'd31;
                        state_d = S_ITERATE;
                    end
                end
                S_ITERATE: begin
                    rem_d   = w_fits ? w_trial[31:0] : w_shift[31:0];
                    quo_d   = {quo_q[30:0], w_fits};
                    count_d = count_q - 5'd1;
                    if (count_q == 5'd0) begin
                        state_d = S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    quotient_d  = w_fix_quo;
                    remainder_d = w_fix_rem;
                    zero_d      = (w_fix_quo == 32'd0);
                    neg_d       = w_fix_quo[31];
                    div0_d      = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);
    assign flags_load_o    = (state_q == S_DONE);
    assign quotient_o      = quotient_q;
    assign remainder_o     = remainder_q;
    assign flag_zero_o     = zero_q;
    assign flag_negative_o = neg_q;
    assign flag_div0_o     = div0_q;
    assign flag_overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Iterative 32-bit integer divide unit with its own sequencing FSM, used by the cpu32e2 execute stage for signed and unsigned divide/modulo. It accepts one operation at a time, runs a radix-2 restoring divide (one quotient bit per cycle), applies sign fixup and special-case handling, and presents the registered quotient, remainder and result flags. It also drives `busy` to the controller so dependent instructions stall while a divide is in flight.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  pipeline advance; low freezes all state (abort excepted)
- abort  in  1  pipeline flush; cancels any operation in flight
- start  in  1  request a divide; sampled only in IDLE with enable high
- is_signed  in  1  operands are two's complement when high
- dividend  in  32  numerator, sampled with start
- divisor  in  32  denominator, sampled with start
- busy  out  1  state != IDLE
- done  out  1  state == DONE; result valid
- quotient  out  32  registered quotient
- remainder  out  32  registered remainder
- flags_load  out  1  equals done; tells flags register to load
- flag_zero  out  1  quotient == 0
- flag_negative  out  1  quotient[31]
- flag_div0  out  1  divisor was zero
- flag_overflow  out  1  signed 0x80000000 / 0xFFFFFFFF

## Operation
- States: IDLE, CHECK, ITERATE, FIXUP, DONE.
- IDLE: on start & enable, capture |dividend|, |divisor| (absolute values only when is_signed), signs, is_signed -> CHECK.
- CHECK: divisor == 0 -> quotient 0xFFFFFFFF, remainder = original dividend, flag_div0=1 -> DONE. Signed and dividend 0x80000000 and divisor 0xFFFFFFFF -> quotient 0x80000000, remainder 0, flag_overflow=1 -> DONE. Otherwise clear partial remainder, count=31 -> ITERATE.
- ITERATE: shift {rem, quo} left 1; trial = rem - divisor (33-bit); if non-negative, rem = trial and quotient bit = 1. count decrements; at count == 0 -> FIXUP.
- FIXUP: signed only: negate quotient if operand signs differ; negate remainder if dividend negative (remainder takes dividend sign). Unsigned: no change. -> DONE.
- DONE: outputs and flags registered; done and flags_load high; -> IDLE on next enabled edge.
- flag_zero/flag_negative computed from final quotient in every path including special cases; flag_div0/flag_overflow cleared for normal results.
- quotient, remainder and all flags hold their values until the next operation reaches DONE.
- start while busy ignored (not queued).
- abort: any state -> IDLE on next edge, regardless of enable; no done pulse; quotient/remainder/flags keep previous values.
- enable low: state, counter, working registers frozen; in DONE, done/flags_load stay high until enable returns (consumer samples only when enable high).

## Timing
- Reset: state IDLE, busy 0, done 0, flags_load 0, quotient 0, remainder 0, all flags 0.
- start sampled at edge E0; CHECK in cycle 1; ITERATE cycles 2-33 (32 cycles); FIXUP cycle 34; DONE cycle 35 (done high for one enabled cycle).
- Special cases: DONE in cycle 2.
- Back-to-back: start accepted earliest in cycle after DONE (IDLE); normal throughput 36 cycles/op.
- Each low-enable cycle extends latency by exactly one cycle.
- abort and start same cycle in IDLE: abort wins, no operation starts.
- All outputs registered or decoded from state register; no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7 -> quotient 14, remainder 2, done in cycle 35, all flags 0, busy high cycles 1-35.
- Signed -7 / 2 (0xFFFFFFF9, 2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, flag_negative 1; same operands unsigned -> quotient 0x7FFFFFFC, remainder 1.
- 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, flag_div0 1, flag_negative 1, done in cycle 2; then signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, flag_overflow 1, done in cycle 2.
- 3 / 10 -> quotient 0, remainder 3, flag_zero 1; start pulses during busy ignored.
- abort in cycle 10 of 100 / 7 -> busy low next cycle, no done, previous results held; subsequent 9 / 3 -> quotient 3, remainder 0 at cycle 35.
- enable low for 5 cycles during ITERATE -> done in cycle 40 with correct result; enable low in DONE holds done high; reset asserted mid-ITERATE -> all outputs zero immediately.
